// File: rtl/imem_loader_if.sv
// Bundles the UART byte stream, load control/status and the instruction RAM
// write port of the program loader; slave is the loader, master its environment.
interface imem_loader_if #(
  parameter int ADDR_W = 16
);
  logic              load_req;
  logic              uart_done;
  logic [7:0]        buffer;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [7:0]        ram_din;
  logic              cpu_hold;
  logic              load_busy;
  logic              load_ok;
  logic              load_err;
  logic [1:0]        err_code;

  modport master (
    output load_req, uart_done, buffer,
    input  ram_we, ram_addr, ram_din, cpu_hold, load_busy, load_ok, load_err, err_code
  );

  modport slave (
    input  load_req, uart_done, buffer,
    output ram_we, ram_addr, ram_din, cpu_hold, load_busy, load_ok, load_err, err_code
  );
endinterface

// File: rtl/imem_loader.sv
// Frames a length/data/checksum packet from the UART into instruction RAM byte
// writes and keeps the core held until a checksum-verified image is loaded.
module imem_loader #(
  parameter int ADDR_W  = 16,
  parameter int TIMEOUT = 1_000_000
) (
  input logic          clk,
  input logic          rst,
  imem_loader_if.slave bus
);

  localparam int               CNT_W   = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);
  localparam logic [32:0]      MAX_LEN = 33'd1 << ADDR_W;

  localparam logic [1:0] ERR_TIMEOUT  = 2'b01;
  localparam logic [1:0] ERR_OVERFLOW = 2'b10;
  localparam logic [1:0] ERR_CHECKSUM = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    LEN_LO,
    LEN_HI,
    DATA,
    CSUM,
    DONE,
    ERR
  } state_t;

  state_t            state;
  logic [7:0]        len_lo;
  logic [ADDR_W:0]   len;
  logic [ADDR_W:0]   index;
  logic [ADDR_W:0]   next_index;
  logic [7:0]        sum;
  logic [CNT_W-1:0]  tcnt;
  logic              start;
  logic              busy_state;

  // A new download is only accepted when no download is currently running.
  assign start      = bus.load_req && (state == IDLE || state == DONE || state == ERR);
  assign busy_state = (state == LEN_LO) || (state == LEN_HI) || (state == DATA) || (state == CSUM);
  assign next_index = index + {{ADDR_W{1'b0}}, 1'b1};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      len_lo        <= '0;
      len           <= '0;
      index         <= '0;
      sum           <= '0;
      tcnt          <= '0;
      bus.ram_we    <= 1'b0;
      bus.ram_addr  <= '0;
      bus.ram_din   <= '0;
      bus.cpu_hold  <= 1'b1;
      bus.load_busy <= 1'b0;
      bus.load_ok   <= 1'b0;
      bus.load_err  <= 1'b0;
      bus.err_code  <= 2'b00;
    end else begin
      bus.ram_we <= 1'b0;
      if (start) begin
        state         <= LEN_LO;
        index         <= '0;
        sum           <= '0;
        tcnt          <= '0;
        bus.cpu_hold  <= 1'b1;
        bus.load_busy <= 1'b1;
        bus.load_ok   <= 1'b0;
        bus.load_err  <= 1'b0;
        bus.err_code  <= 2'b00;
      end else if (busy_state) begin
        // A byte arriving on the same edge as the timeout takes priority.
        if (bus.uart_done) begin
          tcnt <= '0;
          case (state)
            LEN_LO: begin
              len_lo <= bus.buffer;
              state  <= LEN_HI;
            end
            LEN_HI: begin
              if ({17'd0, bus.buffer, len_lo} > MAX_LEN) begin
                state         <= ERR;
                bus.load_busy <= 1'b0;
                bus.load_err  <= 1'b1;
                bus.err_code  <= ERR_OVERFLOW;
              end else begin
                len   <= (ADDR_W + 1)'({bus.buffer, len_lo});
                state <= ({bus.buffer, len_lo} == 16'd0) ? CSUM : DATA;
              end
            end
            DATA: begin
              bus.ram_we   <= 1'b1;
              bus.ram_addr <= index[ADDR_W-1:0];
              bus.ram_din  <= bus.buffer;
              sum          <= sum + bus.buffer;
              index        <= next_index;
              if (next_index == len) state <= CSUM;
            end
            CSUM: begin
              bus.load_busy <= 1'b0;
              if (bus.buffer == sum) begin
                state        <= DONE;
                bus.load_ok  <= 1'b1;
                bus.cpu_hold <= 1'b0;
              end else begin
                state        <= ERR;
                bus.load_err <= 1'b1;
                bus.err_code <= ERR_CHECKSUM;
              end
            end
            default: state <= state;
          endcase
        end else if (tcnt == CNT_MAX) begin
          state         <= ERR;
          bus.load_busy <= 1'b0;
          bus.load_err  <= 1'b1;
          bus.err_code  <= ERR_TIMEOUT;
        end else begin
          tcnt <= tcnt + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: expected RAM writes are queued as data
// bytes are driven and matched against the write port one cycle later.
module tb_imem_loader;

  localparam int ADDR_W  = 4;
  localparam int TIMEOUT = 100;

  typedef struct {
    int         addr;
    logic [7:0] data;
  } wr_t;

  logic clk;
  logic rst;
  int   errors;
  int   checks;
  wr_t  exp_q[$];

  imem_loader_if #(.ADDR_W(ADDR_W)) bus ();

  imem_loader #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, actual, expected, $time);
    end
  endtask

  task automatic check_status(input string tag, input logic busy, input logic hold,
                              input logic ok, input logic err, input logic [1:0] code);
    checkOutput({tag, "_busy"}, 32'(bus.load_busy), 32'(busy));
    checkOutput({tag, "_hold"}, 32'(bus.cpu_hold), 32'(hold));
    checkOutput({tag, "_ok"}, 32'(bus.load_ok), 32'(ok));
    checkOutput({tag, "_err"}, 32'(bus.load_err), 32'(err));
    checkOutput({tag, "_code"}, 32'(bus.err_code), 32'(code));
  endtask

  // Drives one byte for one cycle; data bytes also queue their expected write.
  task automatic applyStimulus(input logic [7:0] b, input bit is_data, input int addr);
    wr_t w;
    if (is_data) begin
      w.addr = addr;
      w.data = b;
      exp_q.push_back(w);
    end
    bus.uart_done = 1'b1;
    bus.buffer    = b;
    @(negedge clk);
    bus.uart_done = 1'b0;
    bus.buffer    = 8'h00;
  endtask

  task automatic pulse_load();
    bus.load_req = 1'b1;
    @(negedge clk);
    bus.load_req = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Random packet of n bytes; optionally fires an ignored load_req mid-stream.
  task automatic send_random(input int n, input bit mid_req);
    logic [7:0] s;
    logic [7:0] b;
    logic [15:0] len;
    s   = 8'h00;
    len = 16'(n);
    applyStimulus(len[7:0], 1'b0, 0);
    applyStimulus(len[15:8], 1'b0, 0);
    for (int i = 0; i < n; i++) begin
      b = 8'($urandom_range(0, 255));
      s = s + b;
      applyStimulus(b, 1'b1, i);
      if (mid_req && i == 1) pulse_load();
    end
    applyStimulus(s, 1'b0, 0);
  endtask

  // Write-port monitor: any write or any pending expected write is checked.
  always @(posedge clk) begin
    wr_t w;
    #1;
    if (bus.ram_we || exp_q.size() != 0) begin
      checkOutput("ram_we", 32'(bus.ram_we), 32'd1);
      if (exp_q.size() != 0) begin
        w = exp_q.pop_front();
        if (bus.ram_we) begin
          checkOutput("ram_addr", 32'(bus.ram_addr), 32'(w.addr));
          checkOutput("ram_din", 32'(bus.ram_din), 32'(w.data));
        end
      end
    end
  end

  initial begin
    errors        = 0;
    checks        = 0;
    rst           = 1'b1;
    bus.load_req  = 1'b0;
    bus.uart_done = 1'b0;
    bus.buffer    = 8'h00;
    idle_cycles(3);
    check_status("reset", 1'b0, 1'b1, 1'b0, 1'b0, 2'b00);
    checkOutput("reset_we", 32'(bus.ram_we), 32'd0);
    checkOutput("reset_addr", 32'(bus.ram_addr), 32'd0);
    checkOutput("reset_din", 32'(bus.ram_din), 32'd0);
    rst = 1'b0;
    idle_cycles(2);
    check_status("idle", 1'b0, 1'b1, 1'b0, 1'b0, 2'b00);

    $display("[TB] basic 4-byte image");
    pulse_load();
    check_status("start", 1'b1, 1'b1, 1'b0, 1'b0, 2'b00);
    applyStimulus(8'h04, 1'b0, 0);
    applyStimulus(8'h00, 1'b0, 0);
    applyStimulus(8'h13, 1'b1, 0);
    applyStimulus(8'h00, 1'b1, 1);
    applyStimulus(8'h00, 1'b1, 2);
    applyStimulus(8'h00, 1'b1, 3);
    check_status("before_csum", 1'b1, 1'b1, 1'b0, 1'b0, 2'b00);
    applyStimulus(8'h13, 1'b0, 0);
    check_status("good", 1'b0, 1'b0, 1'b1, 1'b0, 2'b00);

    $display("[TB] bad checksum then reload");
    pulse_load();
    applyStimulus(8'h04, 1'b0, 0);
    applyStimulus(8'h00, 1'b0, 0);
    applyStimulus(8'h13, 1'b1, 0);
    applyStimulus(8'h00, 1'b1, 1);
    applyStimulus(8'h00, 1'b1, 2);
    applyStimulus(8'h00, 1'b1, 3);
    applyStimulus(8'h14, 1'b0, 0);
    check_status("bad_csum", 1'b0, 1'b1, 1'b0, 1'b1, 2'b11);
    pulse_load();
    check_status("restart", 1'b1, 1'b1, 1'b0, 1'b0, 2'b00);
    send_random(8, 1'b1);
    check_status("reload", 1'b0, 1'b0, 1'b1, 1'b0, 2'b00);

    $display("[TB] empty image");
    pulse_load();
    applyStimulus(8'h00, 1'b0, 0);
    applyStimulus(8'h00, 1'b0, 0);
    applyStimulus(8'h00, 1'b0, 0);
    check_status("empty", 1'b0, 1'b0, 1'b1, 1'b0, 2'b00);

    $display("[TB] timeout");
    pulse_load();
    applyStimulus(8'h04, 1'b0, 0);
    applyStimulus(8'h00, 1'b0, 0);
    applyStimulus(8'h13, 1'b1, 0);
    idle_cycles(TIMEOUT - 1);
    check_status("pre_timeout", 1'b1, 1'b1, 1'b0, 1'b0, 2'b00);
    idle_cycles(1);
    check_status("timeout", 1'b0, 1'b1, 1'b0, 1'b1, 2'b01);

    $display("[TB] byte on the timeout cycle");
    pulse_load();
    applyStimulus(8'h04, 1'b0, 0);
    applyStimulus(8'h00, 1'b0, 0);
    applyStimulus(8'h13, 1'b1, 0);
    idle_cycles(TIMEOUT - 1);
    applyStimulus(8'h00, 1'b1, 1);
    check_status("late_byte", 1'b1, 1'b1, 1'b0, 1'b0, 2'b00);
    applyStimulus(8'h00, 1'b1, 2);
    applyStimulus(8'h00, 1'b1, 3);
    applyStimulus(8'h13, 1'b0, 0);
    check_status("late_done", 1'b0, 1'b0, 1'b1, 1'b0, 2'b00);

    $display("[TB] length limits");
    pulse_load();
    applyStimulus(8'h11, 1'b0, 0);
    applyStimulus(8'h00, 1'b0, 0);
    check_status("overflow", 1'b0, 1'b1, 1'b0, 1'b1, 2'b10);
    idle_cycles(2);
    pulse_load();
    send_random(16, 1'b0);
    check_status("full", 1'b0, 1'b0, 1'b1, 1'b0, 2'b00);
    checkOutput("full_last_addr", 32'(bus.ram_addr), 32'd15);

    $display("[TB] reset during data");
    pulse_load();
    applyStimulus(8'h08, 1'b0, 0);
    applyStimulus(8'h00, 1'b0, 0);
    applyStimulus(8'hA5, 1'b1, 0);
    applyStimulus(8'h5A, 1'b1, 1);
    applyStimulus(8'h3C, 1'b1, 2);
    rst = 1'b1;
    #1;
    check_status("mid_rst", 1'b0, 1'b1, 1'b0, 1'b0, 2'b00);
    checkOutput("mid_rst_addr", 32'(bus.ram_addr), 32'd0);
    checkOutput("mid_rst_din", 32'(bus.ram_din), 32'd0);
    checkOutput("mid_rst_we", 32'(bus.ram_we), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    idle_cycles(1);
    applyStimulus(8'h04, 1'b0, 0);
    applyStimulus(8'h00, 1'b0, 0);
    applyStimulus(8'h77, 1'b0, 0);
    check_status("idle_bytes", 1'b0, 1'b1, 1'b0, 1'b0, 2'b00);
    pulse_load();
    send_random(4, 1'b0);
    check_status("after_rst", 1'b0, 1'b0, 1'b1, 1'b0, 2'b00);

    idle_cycles(3);
    checkOutput("pending_writes", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
